// File: rtl/seq_detect_pkg.sv
// Shared limits, default pattern and the elaboration-time transition function
// for the parametrised serial pattern detectors.
package seq_detect_pkg;

  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MAX = 32;
  localparam logic [PAT_W_MAX-1:0] DEFAULT_PATTERN = 16'b101;

  // Longest pattern prefix that is a suffix of (prefix[0..s-1], b); pattern
  // bit pat_w-1 is the first bit received. A completed match without overlap
  // restarts from the empty prefix.
  function automatic int next_state(input logic [PAT_W_MAX-1:0] pattern,
                                    input int pat_w, input bit overlap,
                                    input int s, input logic b);
    int st, len, best, j;
    bit ok;
    logic [PAT_W_MAX-1:0] sh;
    logic sj, pj;
    st   = (s >= pat_w && !overlap) ? 0 : s;
    len  = st + 1;
    best = 0;
    for (int k = 1; k <= PAT_W_MAX; k++) begin
      if (k <= len && k <= pat_w) begin
        ok = 1'b1;
        for (int i = 0; i < PAT_W_MAX; i++) begin
          if (i < k) begin
            j = len - k + i;
            if (j < st) begin
              sh = pattern >> (pat_w - 1 - j);
              sj = sh[0];
            end else begin
              sj = b;
            end
            sh = pattern >> (pat_w - 1 - i);
            pj = sh[0];
            if (sj != pj) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter with a sticky saturation flag; clear wins over inc.
module seq_match_counter
  import seq_detect_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_match_counter: CNT_W out of range 1..%0d", CNT_W_MAX);
  end

  logic [CNT_W-1:0] count_inc;
  assign count_inc = count + CNT_W'(1);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && !(&count)) begin
      count <= count_inc;
      if (&count_inc) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_moore.sv
// Moore detector for a fixed PAT_W-bit serial pattern with a saturating match counter.
//   state       | meaning
//   0..PAT_W-1  | that many leading pattern bits seen as the newest accepted bits
//   PAT_W       | full pattern seen, out = 1
module seq_detect_moore
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             clear,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  if (PAT_W < 1 || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detect_moore: PAT_W out of range 1..%0d", PAT_W_MAX);
  end

  localparam int SW = $clog2(PAT_W + 1);
  typedef logic [SW-1:0] state_t;
  localparam state_t S_MATCH = state_t'(PAT_W);

  state_t state_q, state_d;
  state_t tab [0:PAT_W][0:1];
  logic   inc;

  // Transition table folded to constants from PATTERN at elaboration.
  for (genvar gs = 0; gs <= PAT_W; gs++) begin : g_row
    for (genvar gb = 0; gb < 2; gb++) begin : g_col
      localparam int NS = next_state(PAT_W_MAX'(PATTERN), PAT_W, OVERLAP, gs, (gb != 0));
      assign tab[gs][gb] = state_t'(NS);
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state_q <= '0;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    if (clear) begin
      state_d = '0;
    end else if (in_valid) begin
      state_d = tab[state_q][in];
      inc     = (state_d == S_MATCH);
    end
  end

  assign out = (state_q == S_MATCH);

  seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .areset_n (areset_n),
    .inc      (inc),
    .clear    (clear),
    .count    (match_count),
    .sat      (count_sat)
  );

endmodule

// File: tb/tb_seq_detect_moore.sv
// Bench for seq_detect_moore: several parameterisations share one input stream,
// checked against vector tables, hand sequences and a suffix-matching model.
module tb_seq_detect_moore;

  localparam int N = 6;
  localparam int PW [N] = '{3, 3, 3, 3, 1, 5};
  localparam int PV [N] = '{5, 5, 7, 5, 0, 27};
  localparam int OV [N] = '{1, 0, 1, 1, 1, 0};
  localparam int CW [N] = '{8, 8, 8, 2, 1, 4};

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  logic in = 1'b0, in_valid = 1'b0, clear = 1'b0;
  logic [N-1:0] out_v, sat_v;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;
  logic [0:0] c4;
  logic [3:0] c5;

  always #5 clk = ~clk;

  seq_detect_moore #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clk(clk), .areset_n(areset_n), .in(in), .in_valid(in_valid), .clear(clear),
    .out(out_v[0]), .match_count(c0), .count_sat(sat_v[0]));
  seq_detect_moore #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) u1 (
    .clk(clk), .areset_n(areset_n), .in(in), .in_valid(in_valid), .clear(clear),
    .out(out_v[1]), .match_count(c1), .count_sat(sat_v[1]));
  seq_detect_moore #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(8)) u2 (
    .clk(clk), .areset_n(areset_n), .in(in), .in_valid(in_valid), .clear(clear),
    .out(out_v[2]), .match_count(c2), .count_sat(sat_v[2]));
  seq_detect_moore #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) u3 (
    .clk(clk), .areset_n(areset_n), .in(in), .in_valid(in_valid), .clear(clear),
    .out(out_v[3]), .match_count(c3), .count_sat(sat_v[3]));
  seq_detect_moore #(.PAT_W(1), .PATTERN(1'b0), .OVERLAP(1'b1), .CNT_W(1)) u4 (
    .clk(clk), .areset_n(areset_n), .in(in), .in_valid(in_valid), .clear(clear),
    .out(out_v[4]), .match_count(c4), .count_sat(sat_v[4]));
  seq_detect_moore #(.PAT_W(5), .PATTERN(5'b11011), .OVERLAP(1'b0), .CNT_W(4)) u5 (
    .clk(clk), .areset_n(areset_n), .in(in), .in_valid(in_valid), .clear(clear),
    .out(out_v[5]), .match_count(c5), .count_sat(sat_v[5]));

  int tests = 0;
  int fails = 0;

  // Reference model: accepted-bit history, matched by brute-force suffix search.
  bit hist [N][$];
  int mst  [N];
  int mcnt [N];
  bit msat [N];

  function automatic int cnt_of(input int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      3: return int'(c3);
      4: return int'(c4);
      default: return int'(c5);
    endcase
  endfunction

  function automatic bit pbit(input int i, input int pos);
    int v;
    v = PV[i] >> (PW[i] - 1 - pos);
    return v[0];
  endfunction

  function automatic int longest(input int i);
    int n, best;
    bit ok;
    n = hist[i].size();
    best = 0;
    for (int k = 1; k <= PW[i]; k++) begin
      if (k <= n) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (hist[i][n-k+j] != pbit(i, j)) ok = 1'b0;
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      hist[i].delete();
      mst[i] = 0; mcnt[i] = 0; msat[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit b, input bit v, input bit c);
    int maxc;
    for (int i = 0; i < N; i++) begin
      maxc = (1 << CW[i]) - 1;
      if (c) begin
        hist[i].delete();
        mst[i] = 0; mcnt[i] = 0; msat[i] = 1'b0;
      end else if (v) begin
        hist[i].push_back(b);
        if (hist[i].size() > 16) void'(hist[i].pop_front());
        mst[i] = longest(i);
        if (mst[i] == PW[i]) begin
          if (mcnt[i] < maxc) mcnt[i]++;
          if (mcnt[i] == maxc) msat[i] = 1'b1;
          if (OV[i] == 0) hist[i].delete();
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cycle(input bit b, input bit v, input bit c);
    in = b; in_valid = v; clear = c;
    @(posedge clk);
    model_edge(b, v, c);
    #1;
  endtask

  task automatic async_assert();
    #2 areset_n = 1'b0;
    #1 model_reset();
  endtask

  task automatic async_release();
    @(negedge clk);
    areset_n = 1'b1;
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s out[%0d]", tag, i), int'(out_v[i]), int'(mst[i] == PW[i]));
      chk($sformatf("%s count[%0d]", tag, i), cnt_of(i), mcnt[i]);
      chk($sformatf("%s sat[%0d]", tag, i), int'(sat_v[i]), int'(msat[i]));
    end
  endtask

  typedef struct {
    bit b, v, c;
    bit o0, o1, o2;
    int k0, k1, k2, k3;
    bit s3;
  } vec_t;

  vec_t tbl [22];

  initial begin
    tbl[0]  = '{1,1,0, 0,0,0, 0,0,0,0, 0};
    tbl[1]  = '{0,1,0, 0,0,0, 0,0,0,0, 0};
    tbl[2]  = '{1,1,0, 1,1,0, 1,1,0,1, 0};
    tbl[3]  = '{0,1,0, 0,0,0, 1,1,0,1, 0};
    tbl[4]  = '{1,1,0, 1,0,0, 2,1,0,2, 0};
    tbl[5]  = '{1,1,0, 0,0,0, 2,1,0,2, 0};
    tbl[6]  = '{1,1,0, 0,0,1, 2,1,1,2, 0};
    tbl[7]  = '{1,1,0, 0,0,1, 2,1,2,2, 0};
    tbl[8]  = '{1,1,0, 0,0,1, 2,1,3,2, 0};
    tbl[9]  = '{1,0,0, 0,0,1, 2,1,3,2, 0};
    tbl[10] = '{0,1,0, 0,0,0, 2,1,3,2, 0};
    tbl[11] = '{1,1,0, 1,1,0, 3,2,3,3, 1};
    tbl[12] = '{0,1,1, 0,0,0, 0,0,0,0, 0};
    tbl[13] = '{1,1,0, 0,0,0, 0,0,0,0, 0};
    tbl[14] = '{0,1,0, 0,0,0, 0,0,0,0, 0};
    tbl[15] = '{1,0,0, 0,0,0, 0,0,0,0, 0};
    tbl[16] = '{0,0,0, 0,0,0, 0,0,0,0, 0};
    tbl[17] = '{1,0,0, 0,0,0, 0,0,0,0, 0};
    tbl[18] = '{0,0,0, 0,0,0, 0,0,0,0, 0};
    tbl[19] = '{1,1,0, 1,1,0, 1,1,0,1, 0};
    tbl[20] = '{0,1,0, 0,0,0, 1,1,0,1, 0};
    tbl[21] = '{1,1,1, 0,0,0, 0,0,0,0, 0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset out[%0d]", i), int'(out_v[i]), 0);
      chk($sformatf("reset count[%0d]", i), cnt_of(i), 0);
      chk($sformatf("reset sat[%0d]", i), int'(sat_v[i]), 0);
    end
    async_release();

    // Vector table: basic overlap/non-overlap, 111 runs, valid gaps, clear.
    for (int r = 0; r < 22; r++) begin
      cycle(tbl[r].b, tbl[r].v, tbl[r].c);
      chk($sformatf("tbl%0d out0", r), int'(out_v[0]), int'(tbl[r].o0));
      chk($sformatf("tbl%0d out1", r), int'(out_v[1]), int'(tbl[r].o1));
      chk($sformatf("tbl%0d out2", r), int'(out_v[2]), int'(tbl[r].o2));
      chk($sformatf("tbl%0d out3", r), int'(out_v[3]), int'(tbl[r].o0));
      chk($sformatf("tbl%0d count0", r), int'(c0), tbl[r].k0);
      chk($sformatf("tbl%0d count1", r), int'(c1), tbl[r].k1);
      chk($sformatf("tbl%0d count2", r), int'(c2), tbl[r].k2);
      chk($sformatf("tbl%0d count3", r), int'(c3), tbl[r].k3);
      chk($sformatf("tbl%0d sat3", r), int'(sat_v[3]), int'(tbl[r].s3));
      chk($sformatf("tbl%0d sat0", r), int'(sat_v[0]), 0);
    end

    // Async reset while holding a partial match of 101 (state 2, one match counted).
    cycle(1,1,0); cycle(0,1,0); cycle(1,1,0); cycle(0,1,0);
    chk("pre-reset count0", int'(c0), 1);
    async_assert();
    chk("async out0", int'(out_v[0]), 0);
    chk("async count0", int'(c0), 0);
    chk("async count3", int'(c3), 0);
    async_release();
    cycle(0,1,0);
    chk("post-reset bit0 out0", int'(out_v[0]), 0);
    cycle(1,1,0);
    chk("post-reset bit1 out0", int'(out_v[0]), 0);
    chk("post-reset count0", int'(c0), 0);
    cycle(0,1,0);
    async_assert();
    async_release();
    cycle(1,1,0);
    chk("reset from state2 then 1 out0", int'(out_v[0]), 0);

    // Two-bit counter saturation on overlapping 101 matches.
    cycle(0,1,1);
    for (int k = 1; k <= 9; k++) begin
      int m;
      cycle(bit'(k % 2), 1'b1, 1'b0);
      if (k >= 3 && (k % 2) == 1) begin
        m = (k - 1) / 2;
        chk($sformatf("sat seq bit%0d count3", k), int'(c3), (m > 3) ? 3 : m);
        chk($sformatf("sat seq bit%0d sat3", k), int'(sat_v[3]), int'(m >= 3));
        chk($sformatf("sat seq bit%0d count0", k), int'(c0), m);
      end
    end

    // Randomised stream against the reference model.
    cycle(0,0,1);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_assert();
        compare_all("rst");
        async_release();
      end
      cycle(bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 9) < 8),
            bit'($urandom_range(0, 49) == 0));
      compare_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
